song_sequencer: RTL and testbench

//  Auto-play note sequencer. Sits directly upstream of the buzzer.

---
 rtl/song_sequencer.sv | 143 ++++++++++++++
 tb/tb_song_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// rtl/song_sequencer.sv - auto-play note sequencer walking a song ROM
// Emits timed notes with a silent gap between them; pause freezes timing and mutes.
module song_sequencer #(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int SEL_W       = 2,
  parameter int IDX_W       = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  input  logic [SEL_W-1:0]       song_sel,
  output logic [SEL_W+IDX_W-1:0] rom_addr,
  input  logic [9:0]             rom_data,
  output logic [3:0]             note,
  output logic [1:0]             octave_auto,
  output logic                   playing,
  output logic                   song_done
);

  localparam int PW = $clog2(BEAT_CYCLES);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(BEAT_CYCLES - 1);
  localparam logic [PW-1:0]    GAP_START = PW'(BEAT_CYCLES - GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = '1;

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    prescaler;
  logic [3:0]       beat_cnt;
  logic [IDX_W-1:0] idx;
  logic [SEL_W-1:0] sel_q;
  logic [3:0]       note_q;
  logic [1:0]       oct_q;
  logic             abort;
  logic             pre_wrap;
  logic [3:0]       rom_note;
  logic [1:0]       rom_oct;
  logic [3:0]       rom_dur;

  assign abort    = stop | ~enable;
  assign pre_wrap = (prescaler == PRE_LAST);
  assign rom_note = rom_data[9:6];
  assign rom_oct  = rom_data[5:4];
  assign rom_dur  = rom_data[3:0];
  assign rom_addr = {sel_q, idx};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = FETCH;
        FETCH:   state_nx = (rom_dur == 4'd0) ? DONE : PLAY;
        PLAY:    if (!pause && beat_cnt == 4'd1 && prescaler == GAP_START) state_nx = GAP;
        GAP:     if (!pause && pre_wrap) state_nx = (idx == IDX_LAST) ? DONE : FETCH;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // The prescaler keeps running from PLAY into GAP, so GAP ends on its wrap.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      prescaler <= '0;
      beat_cnt  <= '0;
      idx       <= '0;
      sel_q     <= '0;
      note_q    <= '0;
      oct_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sel_q <= song_sel;
          idx   <= '0;
        end
        FETCH: if (rom_dur != 4'd0) begin
          note_q    <= rom_note[3] ? 4'd0 : rom_note;
          oct_q     <= rom_oct;
          beat_cnt  <= rom_dur;
          prescaler <= '0;
        end
        PLAY: if (!pause) begin
          if (pre_wrap) begin
            prescaler <= '0;
            beat_cnt  <= beat_cnt - 4'd1;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        GAP: if (!pause) begin
          if (pre_wrap) begin
            prescaler <= '0;
            if (idx != IDX_LAST) idx <= idx + IDX_W'(1);
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        DONE: begin
          prescaler <= '0;
          beat_cnt  <= '0;
          idx       <= '0;
          sel_q     <= '0;
          note_q    <= '0;
          oct_q     <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    note        = '0;
    octave_auto = '0;
    playing     = 1'b0;
    song_done   = 1'b0;
    case (state)
      FETCH: playing = 1'b1;
      PLAY: begin
        playing     = 1'b1;
        octave_auto = oct_q;
        if (!pause) note = note_q;
      end
      GAP: begin
        playing     = 1'b1;
        octave_auto = oct_q;
      end
      DONE:    song_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_song_sequencer.sv
// tb/tb_song_sequencer.sv - scoreboard bench for song_sequencer
// Expected note/done events are queued at each start and matched as the DUT emits them.
module tb_song_sequencer;

  localparam int B = 10;
  localparam int G = 2;

  logic       clk, rst, enable, start, stop, pause;
  logic [1:0] song_sel;
  logic [5:0] rom_addr;
  logic [9:0] rom_data;
  logic [3:0] note;
  logic [1:0] octave_auto;
  logic       playing, song_done;

  song_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .SEL_W(2), .IDX_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .stop(stop), .pause(pause),
    .song_sel(song_sel), .rom_addr(rom_addr), .rom_data(rom_data), .note(note),
    .octave_auto(octave_auto), .playing(playing), .song_done(song_done)
  );

  typedef struct {
    int kind;
    int nt;
    int oc;
    int len;
    int t;
  } ev_t;

  ev_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc_cnt = 0;
  int  tref = 0;

  function automatic logic [9:0] rom_entry(input logic [1:0] s, input logic [3:0] i);
    logic [9:0] e;
    e = '0;
    case (s)
      2'd0: case (i)
        4'd0: e = {4'd1, 2'b01, 4'd2};
        4'd1: e = {4'd3, 2'b10, 4'd1};
        default: e = '0;
      endcase
      2'd1: e = {4'(i % 7 + 1), i[1:0], 4'd1};
      2'd2: case (i)
        4'd0: e = {4'd5, 2'b00, 4'd2};
        4'd1: e = {4'd6, 2'b01, 4'd3};
        default: e = '0;
      endcase
      default: case (i)
        4'd0: e = {4'd9, 2'b01, 4'd2};
        4'd1: e = {4'd4, 2'b10, 4'd1};
        default: e = '0;
      endcase
    endcase
    return e;
  endfunction

  assign rom_data = rom_entry(rom_addr[5:4], rom_addr[3:0]);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_note(input int nt, input int oc, input int len, input int t);
    ev_t e;
    e.kind = 0; e.nt = nt; e.oc = oc; e.len = len; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int t);
    ev_t e;
    e.kind = 1; e.nt = 0; e.oc = 0; e.len = 0; e.t = t;
    exp_q.push_back(e);
  endtask

  // Timeline relative to the start edge: fetch at t, note audible from t+1.
  task automatic gen_song(input int song, input int pause_len);
    int t;
    logic [9:0] e;
    t = 0;
    for (int i = 0; i < 16; i++) begin
      e = rom_entry(2'(song), 4'(i));
      if (e[3:0] == 4'd0) begin
        push_done(t + 1);
        return;
      end
      if (e[9:6] >= 4'd1 && e[9:6] <= 4'd7)
        push_note(int'(e[9:6]), int'(e[5:4]), int'(e[3:0]) * B - G, t + 1);
      t = t + 1 + int'(e[3:0]) * B + ((i == 0) ? pause_len : 0);
    end
    push_done(t);
  endtask

  task automatic match(input ev_t a);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("sb_unexpected_event", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check("ev_kind", a.kind, e.kind);
    check("ev_time", a.t, e.t);
    if (e.kind == 0) begin
      check("ev_note", a.nt, e.nt);
      check("ev_oct", a.oc, e.oc);
      check("ev_len", a.len, e.len);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_song(input logic [1:0] s);
    song_sel = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    tref = cyc_cnt;
  endtask

  task automatic sb_drained(input string tag);
    check(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Collapses audible output into note events; a run survives pause-muted cycles.
  initial begin
    bit  run_on;
    ev_t run;
    ev_t d;
    int  t;
    run_on = 0;
    run = '{0, 0, 0, 0, 0};
    forever begin
      @(negedge clk);
      t = cyc_cnt - tref;
      if (note != 4'd0) begin
        if (run_on && int'(note) == run.nt) begin
          run.len++;
        end else begin
          if (run_on) match(run);
          run_on = 1;
          run = '{0, int'(note), int'(octave_auto), 1, t};
        end
      end else if (run_on && !pause) begin
        match(run);
        run_on = 0;
      end
      if (song_done === 1'b1) begin
        d = '{1, 0, 0, 0, t};
        match(d);
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; song_sel = 2'd0;
    cyc(3);
    check("rst_note", note, 0);
    check("rst_oct", octave_auto, 0);
    check("rst_playing", playing, 0);
    check("rst_done", song_done, 0);
    check("rst_addr", rom_addr, 0);
    rst = 1'b0;
    cyc(2);

    // plain song 0
    gen_song(0, 0);
    start_song(2'd0);
    cyc(40);
    sb_drained("song0_drained");
    check("song0_idle", playing, 0);

    // pause for 5 cycles during the first note
    gen_song(0, 5);
    start_song(2'd0);
    cyc(5);
    pause = 1'b1;
    cyc(5);
    pause = 1'b0;
    cyc(40);
    sb_drained("pause_drained");

    // stop during note 3
    push_note(1, 1, 18, 1);
    push_note(3, 2, 4, 22);
    start_song(2'd0);
    cyc(25);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    check("stop_note", note, 0);
    check("stop_playing", playing, 0);
    check("stop_addr", rom_addr, 0);
    cyc(20);
    sb_drained("stop_drained");

    // enable dropped mid-note, then start while disabled
    push_note(1, 1, 10, 1);
    start_song(2'd0);
    cyc(10);
    enable = 1'b0;
    cyc(1);
    check("dis_playing", playing, 0);
    check("dis_note", note, 0);
    start_song(2'd0);
    cyc(3);
    check("dis_start_ignored", playing, 0);
    enable = 1'b1;
    cyc(5);
    sb_drained("dis_drained");

    // song select latched at start
    gen_song(2, 0);
    start_song(2'd2);
    cyc(3);
    song_sel = 2'd1;
    cyc(2);
    check("sel_latched_a", rom_addr[5:4], 2);
    cyc(20);
    check("sel_latched_b", rom_addr[5:4], 2);
    cyc(40);
    sb_drained("song2_drained");

    // full 16-entry song without terminator
    gen_song(1, 0);
    start_song(2'd1);
    cyc(190);
    sb_drained("song1_drained");
    check("song1_idle", playing, 0);

    // out-of-range note muted
    gen_song(3, 0);
    start_song(2'd3);
    cyc(40);
    sb_drained("song3_drained");

    // start during PLAY is ignored
    gen_song(0, 0);
    start_song(2'd0);
    cyc(8);
    song_sel = 2'd3;
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(40);
    sb_drained("restart_drained");

    // reset during PLAY
    push_note(1, 1, 5, 1);
    start_song(2'd0);
    cyc(5);
    rst = 1'b1;
    cyc(1);
    check("mid_rst_note", note, 0);
    check("mid_rst_oct", octave_auto, 0);
    check("mid_rst_playing", playing, 0);
    check("mid_rst_addr", rom_addr, 0);
    check("mid_rst_done", song_done, 0);
    rst = 1'b0;
    cyc(10);
    sb_drained("mid_rst_drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
